// File: rtl/cpu_trace_checker_if.sv
// cpu_trace_checker_if
// Bundles the two buses that feed the trace checker: the CPU commit stream
// (one retired instruction per cycle at most) and the expected-trace load
// port used to preload the checker's memory before a run.
//
// Signals:
//   commit_valid      CPU retired one instruction this cycle
//   commit_pc         pc of the retired instruction
//   commit_we         instruction wrote a register
//   commit_rd         destination register
//   commit_data       written value
//   exp_write_enable  trace-load strobe
//   exp_write_addr    trace-load address
//   exp_write_data    trace-load entry, packed {pc, we, rd, data}
//
// Modports:
//   master  driven by the CPU / trace loader
//   slave   consumed by cpu_trace_checker
interface cpu_trace_checker_if #(
   parameter int DATA_WIDTH     = 16,
   parameter int PC_WIDTH       = 10,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int EXP_DEPTH      = 1024
);

   localparam int IDX_WIDTH   = $clog2(EXP_DEPTH + 1);
   localparam int ENTRY_WIDTH = PC_WIDTH + 1 + REG_ADDR_WIDTH + DATA_WIDTH;

   logic                      commit_valid;
   logic [PC_WIDTH-1:0]       commit_pc;
   logic                      commit_we;
   logic [REG_ADDR_WIDTH-1:0] commit_rd;
   logic [DATA_WIDTH-1:0]     commit_data;

   logic                      exp_write_enable;
   logic [IDX_WIDTH-1:0]      exp_write_addr;
   logic [ENTRY_WIDTH-1:0]    exp_write_data;

   modport master (
      output commit_valid, commit_pc, commit_we, commit_rd, commit_data,
      output exp_write_enable, exp_write_addr, exp_write_data
   );

   modport slave (
      input commit_valid, commit_pc, commit_we, commit_rd, commit_data,
      input exp_write_enable, exp_write_addr, exp_write_data
   );

endinterface

// File: rtl/cpu_trace_checker.sv
// cpu_trace_checker
// Lockstep commit-trace checker. Holds a preloaded trace of expected retired
// instructions and compares the live CPU commit stream against it entry by
// entry, reporting pass, the first mismatch, or a cycle-budget timeout.
// EXP_DEPTH must be at least 2.
//
// Ports:
//   clk              clock, single domain
//   rst              synchronous active-high reset (trace memory is kept)
//   start            begin a check run, accepted in IDLE or DONE
//   exp_count        number of valid expected entries, sampled on start
//   bus              commit stream and trace-load port (slave modport)
//   busy             high while priming or running
//   done             run finished, held until start or rst
//   pass             every expected entry matched
//   fail             mismatch or timeout
//   timeout          fail was caused by the cycle budget
//   err_index        index of the first mismatching entry
//   err_actual       normalised commit at the mismatch
//   err_expected     normalised expected entry at the mismatch
//   commits_matched  entries matched so far
module cpu_trace_checker #(
   parameter int  DATA_WIDTH     = 16,
   parameter int  PC_WIDTH       = 10,
   parameter int  REG_ADDR_WIDTH = 4,
   parameter int  EXP_DEPTH      = 1024,
   parameter int  CYCLE_LIMIT    = 1000,
   localparam int IDX_WIDTH      = $clog2(EXP_DEPTH + 1),
   localparam int CYC_WIDTH      = $clog2(CYCLE_LIMIT + 1),
   localparam int ENTRY_WIDTH    = PC_WIDTH + 1 + REG_ADDR_WIDTH + DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [IDX_WIDTH-1:0]   exp_count,
   cpu_trace_checker_if.slave     bus,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic                   fail,
   output logic                   timeout,
   output logic [IDX_WIDTH-1:0]   err_index,
   output logic [ENTRY_WIDTH-1:0] err_actual,
   output logic [ENTRY_WIDTH-1:0] err_expected,
   output logic [IDX_WIDTH-1:0]   commits_matched
);

   localparam int ADDR_WIDTH = $clog2(EXP_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [ENTRY_WIDTH-1:0] exp_mem [EXP_DEPTH];
   logic [ENTRY_WIDTH-1:0] rd_data;
   logic [IDX_WIDTH-1:0]   rd_addr;

   logic [IDX_WIDTH-1:0]   idx;
   logic [IDX_WIDTH-1:0]   idx_inc;
   logic [IDX_WIDTH-1:0]   exp_count_q;
   logic [CYC_WIDTH-1:0]   cyc_cnt;
   logic                   cycle_last;

   logic [ENTRY_WIDTH-1:0] actual_norm;
   logic [ENTRY_WIDTH-1:0] expected_norm;
   logic                   entry_match;

   logic                   accept_start;
   logic                   take_match;
   logic                   finish_pass;
   logic                   finish_fail;
   logic                   finish_timeout;

   // A register write only counts when we=1 to a non-zero register; anything
   // else collapses to "no writeback" so stray rd/data fields never matter.
   function automatic logic [ENTRY_WIDTH-1:0] normalise(input logic [ENTRY_WIDTH-1:0] e);
      logic                      we;
      logic [REG_ADDR_WIDTH-1:0] rd;
      we = e[DATA_WIDTH + REG_ADDR_WIDTH];
      rd = e[DATA_WIDTH +: REG_ADDR_WIDTH];
      normalise = e;
      if (!we || rd == '0) begin
         normalise[DATA_WIDTH + REG_ADDR_WIDTH:0] = '0;
      end
   endfunction

   // Both sides are normalised before the full-entry equality compare.
   always_comb begin
      actual_norm   = normalise({bus.commit_pc, bus.commit_we, bus.commit_rd, bus.commit_data});
      expected_norm = normalise(rd_data);
      entry_match   = (actual_norm == expected_norm);
      idx_inc       = idx + IDX_WIDTH'(1);
      cycle_last    = (cyc_cnt == CYC_WIDTH'(CYCLE_LIMIT - 1));
      busy          = (state == PRIME) || (state == RUN);
   end

   // Trace memory: loads are locked out while a run is in flight. The read
   // register is frozen during PRIME so that entry 0 is the value read in the
   // start cycle, before any same-cycle write to address 0 lands; writes to
   // other addresses are still seen because they are fetched later.
   always_ff @(posedge clk) begin
      if (bus.exp_write_enable && !busy && bus.exp_write_addr < IDX_WIDTH'(EXP_DEPTH)) begin
         exp_mem[bus.exp_write_addr[ADDR_WIDTH-1:0]] <= bus.exp_write_data;
      end
      if (state != PRIME) begin
         rd_data <= exp_mem[rd_addr[ADDR_WIDTH-1:0]];
      end
   end

   // Next-state and control strobes. The read address runs one entry ahead
   // on a matching commit so back-to-back commits see the next entry without
   // a bubble. A deciding commit (final match or mismatch) takes priority
   // over the cycle budget running out in the same cycle.
   always_comb begin
      state_next     = state;
      rd_addr        = idx;
      accept_start   = 1'b0;
      take_match     = 1'b0;
      finish_pass    = 1'b0;
      finish_fail    = 1'b0;
      finish_timeout = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               accept_start = 1'b1;
               rd_addr      = '0;
               state_next   = PRIME;
            end
         end
         PRIME: begin
            if (exp_count_q == '0) begin
               finish_pass = 1'b1;
               state_next  = DONE;
            end else begin
               state_next  = RUN;
            end
         end
         RUN: begin
            if (bus.commit_valid && entry_match) begin
               take_match = 1'b1;
               rd_addr    = idx_inc;
               if (idx_inc == exp_count_q) begin
                  finish_pass = 1'b1;
                  state_next  = DONE;
               end else if (cycle_last) begin
                  finish_timeout = 1'b1;
                  state_next     = DONE;
               end
            end else if (bus.commit_valid) begin
               finish_fail = 1'b1;
               state_next  = DONE;
            end else if (cycle_last) begin
               finish_timeout = 1'b1;
               state_next     = DONE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register plus run bookkeeping. An accepted start wipes all
   // results so a restart from DONE begins clean; results are otherwise only
   // ever set, and held until the next start or reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         idx             <= '0;
         exp_count_q     <= '0;
         cyc_cnt         <= '0;
         done            <= 1'b0;
         pass            <= 1'b0;
         fail            <= 1'b0;
         timeout         <= 1'b0;
         err_index       <= '0;
         err_actual      <= '0;
         err_expected    <= '0;
         commits_matched <= '0;
      end else begin
         state <= state_next;
         if (accept_start) begin
            exp_count_q     <= exp_count;
            idx             <= '0;
            cyc_cnt         <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail            <= 1'b0;
            timeout         <= 1'b0;
            err_index       <= '0;
            err_actual      <= '0;
            err_expected    <= '0;
            commits_matched <= '0;
         end
         if (state == RUN) begin
            cyc_cnt <= cyc_cnt + CYC_WIDTH'(1);
         end
         if (take_match) begin
            idx             <= idx_inc;
            commits_matched <= commits_matched + IDX_WIDTH'(1);
         end
         if (finish_pass) begin
            done <= 1'b1;
            pass <= 1'b1;
         end
         if (finish_fail) begin
            done         <= 1'b1;
            fail         <= 1'b1;
            err_index    <= idx;
            err_actual   <= actual_norm;
            err_expected <= expected_norm;
         end
         if (finish_timeout) begin
            done      <= 1'b1;
            fail      <= 1'b1;
            timeout   <= 1'b1;
            err_index <= take_match ? idx_inc : idx;
         end
      end
   end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// tb_cpu_trace_checker
// Directed bench for cpu_trace_checker: expected run results are queued when
// a run is launched and popped when the checker raises done.
module tb_cpu_trace_checker;

   localparam int DW    = 16;
   localparam int PW    = 10;
   localparam int RW    = 4;
   localparam int DEPTH = 1024;
   localparam int LIMIT = 1000;
   localparam int IDX_W = $clog2(DEPTH + 1);
   localparam int EW    = PW + 1 + RW + DW;

   typedef struct {
      logic             pass;
      logic             fail;
      logic             timeout;
      logic [IDX_W-1:0] err_index;
      logic [EW-1:0]    err_actual;
      logic [EW-1:0]    err_expected;
      logic [IDX_W-1:0] matched;
   } result_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic [IDX_W-1:0] exp_count;
   logic             busy;
   logic             done;
   logic             pass;
   logic             fail;
   logic             timeout;
   logic [IDX_W-1:0] err_index;
   logic [EW-1:0]    err_actual;
   logic [EW-1:0]    err_expected;
   logic [IDX_W-1:0] commits_matched;

   int tests    = 0;
   int failures = 0;
   result_t sb_q[$];

   logic [EW-1:0] trace [4];
   logic [EW-1:0] commits [4];
   logic [EW-1:0] bad_c2;
   logic [EW-1:0] new_e0;
   logic [EW-1:0] new_e3;

   cpu_trace_checker_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .REG_ADDR_WIDTH(RW), .EXP_DEPTH(DEPTH)) bus ();

   cpu_trace_checker #(
      .DATA_WIDTH(DW), .PC_WIDTH(PW), .REG_ADDR_WIDTH(RW),
      .EXP_DEPTH(DEPTH), .CYCLE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .exp_count(exp_count), .bus(bus),
      .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
      .err_index(err_index), .err_actual(err_actual), .err_expected(err_expected),
      .commits_matched(commits_matched)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the run sequence itself ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no end of sequence, expected finish before time 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [EW-1:0] mk(input logic [PW-1:0] pc, input logic we,
                                        input logic [RW-1:0] rd, input logic [DW-1:0] data);
      return {pc, we, rd, data};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [EW-1:0] e);
      bus.commit_valid = valid;
      {bus.commit_pc, bus.commit_we, bus.commit_rd, bus.commit_data} = e;
      tick();
   endtask

   task automatic loadEntry(input logic [IDX_W-1:0] addr, input logic [EW-1:0] e);
      bus.exp_write_enable = 1'b1;
      bus.exp_write_addr   = addr;
      bus.exp_write_data   = e;
      tick();
      bus.exp_write_enable = 1'b0;
   endtask

   task automatic startRun(input logic [IDX_W-1:0] count);
      start     = 1'b1;
      exp_count = count;
      tick();
      start     = 1'b0;
   endtask

   task automatic expectResult(input logic p, input logic f, input logic t, input logic [IDX_W-1:0] ei,
                               input logic [EW-1:0] ea, input logic [EW-1:0] ee, input logic [IDX_W-1:0] m);
      result_t r;
      r.pass = p; r.fail = f; r.timeout = t; r.err_index = ei;
      r.err_actual = ea; r.err_expected = ee; r.matched = m;
      sb_q.push_back(r);
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
      checkOutput({tag, ".done"}, 64'(done), 64'd0);
      checkOutput({tag, ".pass"}, 64'(pass), 64'd0);
      checkOutput({tag, ".fail"}, 64'(fail), 64'd0);
      checkOutput({tag, ".timeout"}, 64'(timeout), 64'd0);
      checkOutput({tag, ".err_index"}, 64'(err_index), 64'd0);
      checkOutput({tag, ".err_actual"}, 64'(err_actual), 64'd0);
      checkOutput({tag, ".err_expected"}, 64'(err_expected), 64'd0);
      checkOutput({tag, ".matched"}, 64'(commits_matched), 64'd0);
   endtask

   task automatic collectResult(input string tag, input int expected_wait);
      int waited;
      result_t r;
      waited = 0;
      while (!done && waited < 1100) begin
         tick();
         waited++;
      end
      checkOutput({tag, ".latency"}, 64'(waited), 64'(expected_wait));
      if (sb_q.size() == 0) begin
         tests++;
         failures++;
         $error("[TB] FAIL %s.queue: observed empty scoreboard, expected one result", tag);
      end else begin
         r = sb_q.pop_front();
         checkOutput({tag, ".done"}, 64'(done), 64'd1);
         checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
         checkOutput({tag, ".pass"}, 64'(pass), 64'(r.pass));
         checkOutput({tag, ".fail"}, 64'(fail), 64'(r.fail));
         checkOutput({tag, ".timeout"}, 64'(timeout), 64'(r.timeout));
         checkOutput({tag, ".err_index"}, 64'(err_index), 64'(r.err_index));
         checkOutput({tag, ".err_actual"}, 64'(err_actual), 64'(r.err_actual));
         checkOutput({tag, ".err_expected"}, 64'(err_expected), 64'(r.err_expected));
         checkOutput({tag, ".matched"}, 64'(commits_matched), 64'(r.matched));
      end
   endtask

   initial begin
      trace[0]   = mk(10'h000, 1'b1, 4'd1, 16'h0003);
      trace[1]   = mk(10'h001, 1'b0, 4'd0, 16'h0000);
      trace[2]   = mk(10'h002, 1'b1, 4'd2, 16'h0007);
      trace[3]   = mk(10'h003, 1'b1, 4'd3, 16'h00AA);
      commits[0] = trace[0];
      commits[1] = mk(10'h001, 1'b1, 4'd0, 16'h1234);
      commits[2] = trace[2];
      commits[3] = trace[3];
      bad_c2     = mk(10'h002, 1'b1, 4'd2, 16'h0005);
      new_e0     = mk(10'h3FF, 1'b1, 4'd7, 16'hCAFE);
      new_e3     = mk(10'h003, 1'b1, 4'd5, 16'h0BEE);

      rst = 1'b1; start = 1'b0; exp_count = '0;
      bus.commit_valid = 1'b0; bus.commit_pc = '0; bus.commit_we = 1'b0;
      bus.commit_rd = '0; bus.commit_data = '0;
      bus.exp_write_enable = 1'b0; bus.exp_write_addr = '0; bus.exp_write_data = '0;
      tick();
      tick();
      checkIdleOutputs("reset");
      rst = 1'b0;

      for (int i = 0; i < 4; i++) loadEntry(IDX_W'(i), trace[i]);

      // Run 1: four matching commits back-to-back, a stray commit in PRIME.
      expectResult(1'b1, 1'b0, 1'b0, '0, '0, '0, IDX_W'(4));
      startRun(IDX_W'(4));
      checkOutput("run1.prime_busy", 64'(busy), 64'd1);
      applyStimulus(1'b1, bad_c2);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) checkOutput("run1.early_done", 64'(done), 64'd0);
         applyStimulus(1'b1, commits[i]);
      end
      bus.commit_valid = 1'b0;
      collectResult("run1", 0);

      // Run 2: restart from DONE, data mismatch on the third commit.
      expectResult(1'b0, 1'b1, 1'b0, IDX_W'(2), bad_c2, trace[2], IDX_W'(2));
      startRun(IDX_W'(4));
      applyStimulus(1'b0, '0);
      applyStimulus(1'b1, commits[0]);
      applyStimulus(1'b1, commits[1]);
      applyStimulus(1'b1, bad_c2);
      bus.commit_valid = 1'b0;
      collectResult("run2", 0);

      // Run 3: three expected, only two commits, budget expires.
      expectResult(1'b0, 1'b1, 1'b1, IDX_W'(2), '0, '0, IDX_W'(2));
      startRun(IDX_W'(3));
      applyStimulus(1'b0, '0);
      applyStimulus(1'b1, commits[0]);
      applyStimulus(1'b1, commits[1]);
      bus.commit_valid = 1'b0;
      collectResult("run3", LIMIT - 2);

      // Run 4: full trace after the timeout; a write while busy is dropped.
      expectResult(1'b1, 1'b0, 1'b0, '0, '0, '0, IDX_W'(4));
      startRun(IDX_W'(4));
      applyStimulus(1'b0, '0);
      applyStimulus(1'b1, commits[0]);
      bus.exp_write_enable = 1'b1; bus.exp_write_addr = IDX_W'(1); bus.exp_write_data = new_e0;
      applyStimulus(1'b1, commits[1]);
      bus.exp_write_enable = 1'b0;
      applyStimulus(1'b1, commits[2]);
      applyStimulus(1'b1, commits[3]);
      bus.commit_valid = 1'b0;
      collectResult("run4", 0);

      // Run 5: empty trace passes straight out of PRIME.
      expectResult(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
      startRun('0);
      checkOutput("run5.prime_busy", 64'(busy), 64'd1);
      checkOutput("run5.prime_done", 64'(done), 64'd0);
      collectResult("run5", 1);

      // Run 6: reset after two matches aborts the run.
      startRun(IDX_W'(4));
      applyStimulus(1'b0, '0);
      applyStimulus(1'b1, commits[0]);
      applyStimulus(1'b1, commits[1]);
      bus.commit_valid = 1'b0;
      checkOutput("run6.mid_matched", 64'(commits_matched), 64'd2);
      checkOutput("run6.mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkIdleOutputs("run6.abort");

      // Run 7: overwrite entry 3, then start with a same-cycle write to entry 0.
      loadEntry(IDX_W'(3), new_e3);
      expectResult(1'b1, 1'b0, 1'b0, '0, '0, '0, IDX_W'(4));
      bus.exp_write_enable = 1'b1; bus.exp_write_addr = '0; bus.exp_write_data = new_e0;
      startRun(IDX_W'(4));
      bus.exp_write_enable = 1'b0;
      applyStimulus(1'b0, '0);
      applyStimulus(1'b1, commits[0]);
      applyStimulus(1'b1, commits[1]);
      applyStimulus(1'b1, commits[2]);
      applyStimulus(1'b1, new_e3);
      bus.commit_valid = 1'b0;
      collectResult("run7", 0);

      // Run 8: the entry-0 write from the start cycle is now in place.
      expectResult(1'b1, 1'b0, 1'b0, '0, '0, '0, IDX_W'(1));
      startRun(IDX_W'(1));
      applyStimulus(1'b0, '0);
      applyStimulus(1'b1, new_e0);
      bus.commit_valid = 1'b0;
      collectResult("run8", 0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
